// File: rtl/display_source_scheduler_pkg.sv
// Shared widths and the digit sanitiser for the display source scheduler.
package display_pkg;

  localparam int DIGIT_W     = 5;
  localparam int NUM_W       = 20;
  localparam int RANGE_W     = 2;
  localparam int BCD_MAX     = 9;
  localparam int FRAME_W_DEF = 19;
  localparam int N_DIGITS    = NUM_W / DIGIT_W;

  // A digit whose BCD field is not a decimal value is blanked, dp included.
  function automatic logic [NUM_W-1:0] sanitise(input logic [NUM_W-1:0] num);
    logic [NUM_W-1:0] r;
    r = num;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (num[i*DIGIT_W +: 4] > 4'(BCD_MAX))
        r[i*DIGIT_W +: DIGIT_W] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_source_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the start pointer wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] pointer_i,
  input  logic             enable_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  int unsigned pos;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(pointer_i) + k) % N;
      if (enable_i && !any_o && req_i[pos]) begin
        any_o        = 1'b1;
        index_o      = IDX_W'(pos);
        grant_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Frame counter, round-robin source selection and frame-aligned display latches
// for the shared 4-digit seven-segment indicator.
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_FRAMES = 64,
  parameter int FRAME_W      = FRAME_W_DEF
) (
  input  logic                     clk_200MHz,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_req,
  input  logic [N_SRC*NUM_W-1:0]   src_number,
  input  logic [N_SRC*RANGE_W-1:0] src_range,
  input  logic                     hold,
  output logic [N_SRC-1:0]         src_grant,
  output logic [N_SRC-1:0]         src_ack,
  output logic [FRAME_W-1:0]       one_indicator_time,
  output logic [NUM_W-1:0]         displayed_number,
  output logic [RANGE_W-1:0]       mmcn_leds
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int DW_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SHOW = 1'b1;

  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic               state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [RANGE_W-1:0] leds_q, leds_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               boundary;
  logic [N_SRC-1:0]   win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  assign boundary = &cnt_q;

  // ptr_q holds the index the next search starts from (last winner + 1).
  rr_arbiter #(.N(N_SRC), .IDX_W(IDX_W)) u_arb (
    .req_i     (src_req),
    .pointer_i (ptr_q),
    .enable_i  (boundary),
    .grant_o   (win_grant),
    .index_o   (win_idx),
    .any_o     (win_any)
  );

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    num_d   = num_q;
    leds_d  = leds_q;
    dwell_d = dwell_q;
    ptr_d   = ptr_q;
    if (boundary) begin
      if (state_q == ST_IDLE || (!hold && dwell_q == '0)) begin
        if (win_any) begin
          state_d = ST_SHOW;
          grant_d = win_grant;
          ack_d   = win_grant;
          num_d   = sanitise(src_number[32'(win_idx)*NUM_W +: NUM_W]);
          leds_d  = src_range[32'(win_idx)*RANGE_W +: RANGE_W];
          dwell_d = DW_W'(DWELL_FRAMES - 1);
          ptr_d   = (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
        end else if (state_q == ST_SHOW) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end else if (!hold) begin
        dwell_d = dwell_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_200MHz) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      num_q   <= '0;
      leds_q  <= '0;
      dwell_q <= '0;
      ptr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      num_q   <= num_d;
      leds_q  <= leds_d;
      dwell_q <= dwell_d;
      ptr_q   <= ptr_d;
    end
  end

  assign one_indicator_time = cnt_q;
  assign src_grant          = grant_q;
  assign src_ack            = ack_q;
  assign displayed_number   = num_q;
  assign mmcn_leds          = leds_q;

endmodule
